// File: rtl/pp_pkg.sv
// ============================================================================
// pp_pkg : shared constants and the IF/ID bundle type for the pipelined core
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pp_pkg;

   localparam logic [31:0] PP_RESET_PC = 32'h0040_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } if_id_t;

   localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: 32'd0, instr: 32'd0, pc_plus4: 32'd4};

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pp_fetch_skid.sv
// ============================================================================
// pp_fetch_skid : one-entry holding buffer for a fetch response during stall
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_fetch_skid
   import pp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        drain_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q;
   logic [31:0] instr_q;

   // Flush wins over everything; load and drain never coincide.
   always_comb begin
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'd0;
         instr_q <= 32'd0;
      end else begin
         valid_q <= valid_d;
         if (load_i && !flush_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/pp_fetch.sv
// ============================================================================
// pp_fetch : instruction-fetch stage - PC, imem request, skid and IF/ID register
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_fetch
   import pp_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PP_RESET_PC
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_id,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] current_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic        inflight_v_q, inflight_v_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   if_id_t      if_id_q, if_id_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic        issue;
   logic        skid_load, skid_drain, skid_flush;
   logic        skid_v;
   logic [31:0] skid_pc, skid_instr;
   logic        unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign issue     = !stall_id && !redirect_valid;
   assign imem_req  = issue && !rst;
   assign imem_addr = pc_q;

   always_comb begin
      pc_d          = pc_q;
      inflight_v_d  = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if_id_d       = if_id_q;
      fetch_count_d = fetch_count_q;
      skid_load     = 1'b0;
      skid_drain    = 1'b0;
      skid_flush    = 1'b0;

      if (redirect_valid) begin
         // Squash everything younger; the response arriving now is dropped.
         pc_d          = {redirect_pc[31:2], 2'b00};
         if_id_d.valid = 1'b0;
         skid_flush    = 1'b1;
      end else begin
         if (issue) begin
            pc_d          = pc_inc(pc_q);
            inflight_v_d  = 1'b1;
            inflight_pc_d = pc_q;
         end
         if (!stall_id) begin
            if (skid_v) begin
               if_id_d.valid    = 1'b1;
               if_id_d.pc       = skid_pc;
               if_id_d.instr    = skid_instr;
               if_id_d.pc_plus4 = pc_inc(skid_pc);
               skid_drain       = 1'b1;
            end else begin
               if_id_d.valid = inflight_v_q;
               if (inflight_v_q) begin
                  if_id_d.pc       = inflight_pc_q;
                  if_id_d.instr    = imem_rdata;
                  if_id_d.pc_plus4 = pc_inc(inflight_pc_q);
               end
            end
            if (skid_v || inflight_v_q) begin
               fetch_count_d = fetch_count_q + 32'd1;
            end
         end else if (inflight_v_q) begin
            skid_load = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_v_q  <= 1'b0;
         inflight_pc_q <= 32'd0;
         if_id_q       <= IF_ID_RESET;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         inflight_v_q  <= inflight_v_d;
         inflight_pc_q <= inflight_pc_d;
         if_id_q       <= if_id_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   pp_fetch_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .flush_i (skid_flush),
      .pc_i    (inflight_pc_q),
      .instr_i (imem_rdata),
      .valid_o (skid_v),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

   assign current_pc  = pc_q;
   assign if_valid    = if_id_q.valid;
   assign if_pc       = if_id_q.pc;
   assign if_instr    = if_id_q.instr;
   assign if_pc_plus4 = if_id_q.pc_plus4;
   assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: doc/pp_fetch.md
# pp_fetch

Instruction-fetch stage of the five-stage pipelined core. It owns the program counter and issues word reads to the synchronous instruction memory. It buffers the one-cycle-late read data against decode stalls and presents a registered IF/ID bundle (valid, PC, instruction, PC+4) to the decode stage. It also accepts branch/jump redirects from the resolving stage.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall_id  in  1  decode cannot accept; IF/ID must hold
- redirect_valid  in  1  squash all younger work; refetch from redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word-aligned read address (= current_pc)
- imem_rdata  in  32  read data; valid exactly one cycle after imem_req
- current_pc  out  32  PC register (debug/trace)
- if_valid  out  1  IF/ID bundle valid
- if_pc  out  32  PC of bundled instruction
- if_instr  out  32  bundled instruction
- if_pc_plus4  out  32  if_pc + 4
- fetch_count  out  32  instructions loaded into IF/ID since reset

## Operation
- State:
  - pc_q
  - inflight_v/inflight_pc (request issued last cycle)
  - skid_v/skid_pc/skid_instr
  - IF/ID register
  - fetch_count
- Issue:
  - imem_req = !stall_id && !redirect_valid; imem_addr = pc_q.
  - On issue: pc_q <= pc_q+4, inflight_v <= 1, inflight_pc <= pc_q.
  - Otherwise inflight_v <= 0.
- Response: when inflight_v, the response is {inflight_pc, imem_rdata}.
- IF/ID update when !stall_id:
  - If skid_v: load the skid, clear skid_v.
  - Else: load the response; if_valid <= inflight_v.
- IF/ID update when stall_id:
  - IF/ID holds.
  - A response present that cycle goes to the skid (skid_v <= 1).
- Skid never overflows. Responses exist only for requests issued in non-stall cycles, so at most one arrives per stall episode.
- Redirect has priority over stall and issue. In the redirect cycle:
  - imem_req = 0.
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - inflight_v, skid_v and if_valid <= 0.
  - The response arriving in that cycle is discarded.
- if_pc_plus4 is computed from if_pc with 32-bit wrap: 32'hFFFF_FFFC+4 = 0. The PC wraps the same way.
- fetch_count increments on every edge where the IF/ID register loads a valid bundle (!stall_id && !redirect_valid && (skid_v || inflight_v)). It wraps at 2^32.

## Timing
- Reset (async, immediate), all outputs:
  - pc_q = RESET_PC, so current_pc = imem_addr = RESET_PC.
  - imem_req = 0 while rst high.
  - if_valid = 0.
  - if_pc = 0, if_instr = 0, if_pc_plus4 = 4.
  - fetch_count = 0.
  - inflight_v = skid_v = 0.
- Fetch latency:
  - Issue in cycle N; rdata in N+1; if_valid in N+2.
  - Unstalled throughput: 1 instr/cycle.
- Redirect:
  - Asserted in cycle R: if_valid = 0 from R+1.
  - Target issued in R+1; target instruction in IF/ID in R+3.
  - Bubble: 2 cycles.
- Stall release with skid full: the skid bundle appears in the first unstalled cycle +1. The next sequential instruction follows with no bubble.
- rst asserted mid-stream: state clears asynchronously. The in-flight response is ignored.

## Structure
- Shared package pp_pkg:
  - PP_RESET_PC constant.
  - if_id_t struct {valid, pc, instr, pc_plus4}, reused by decode.
- Sub-module pp_fetch_skid: 1-entry holding buffer (load, drain, flush). Instantiated once.

## Test plan
- Reset release, no stall:
  - imem returns 32'h2000_0000|addr[15:0].
  - Cycle 2 after release: if_pc=0x0040_0000, if_instr=0x2000_0000.
  - Consecutive cycles step +4; fetch_count=5 after 5 valid bundles.
- stall_id high for 3 cycles mid-stream:
  - IF/ID frozen.
  - Skid captures the in-flight PC.
  - After release, PCs continue with no gap or duplicate.
- redirect_valid with redirect_pc=0x0040_0103 at cycle R:
  - if_valid=0 in R+1, R+2.
  - R+3 if_pc=0x0040_0100; current_pc never shows a misaligned value.
- redirect_valid and stall_id together while the skid is full:
  - Skid and IF/ID are squashed.
  - Target is fetched once stall drops.
  - fetch_count does not count squashed entries.
- rst pulsed mid-stream:
  - if_valid=0 and current_pc=RESET_PC immediately, before the next edge.
  - Fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC.
  - Next bundle has if_pc=0xFFFF_FFFC, if_pc_plus4=0.
  - The following fetch address is 0x0000_0000.
